iosc_skin_bridge: RTL and testbench



---
 rtl/iosc_skin_bridge_pkg.sv | 25 ++
 rtl/iosc_skin_bridge_if.sv | 24 ++
 rtl/iosc_skin_bridge_irq.sv | 41 ++++
 rtl/iosc_skin_bridge.sv | 158 +++++++++++++++
 tb/tb_iosc_skin_bridge.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iosc_skin_bridge_pkg.sv
// Shared definitions for the IO-switch skin bridge: FSM encodings, local
// register offsets and watchdog error reporting constants.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package iosc_skin_bridge_pkg;

  localparam int IOSC_SKIN_DW = `DATA_WIDTH;

  typedef enum logic [2:0] {
    IOSC_SKIN_IDLE  = 3'd0,
    IOSC_SKIN_LOCAL = 3'd1,
    IOSC_SKIN_PREQ  = 3'd2,
    IOSC_SKIN_DONE  = 3'd3,
    IOSC_SKIN_ERR   = 3'd4
  } iosc_skin_state_e;

  localparam logic [3:0] IOSC_SKIN_PEND_OFF = 4'h0;
  localparam logic [3:0] IOSC_SKIN_MASK_OFF = 4'h4;

  localparam int IOSC_SKIN_ERR_BIT = IOSC_SKIN_DW - 1;
  localparam logic [IOSC_SKIN_DW-1:0] IOSC_SKIN_ERR_RDATA = '1;

endpackage

// File: rtl/iosc_skin_bridge_if.sv
// Peripheral-side req/ack bus of the skin bridge; the bridge is the master.
interface iosc_skin_bridge_if
  import iosc_skin_bridge_pkg::*;
#(
  parameter int DW = IOSC_SKIN_DW
);
  logic          o_per_req;
  logic          o_per_we;
  logic [DW-1:0] o_per_addr;
  logic [DW-1:0] o_per_wdata;
  logic          i_per_ack;
  logic [DW-1:0] i_per_rdata;
  logic [DW-1:0] i_per_irq;

  modport master (
    output o_per_req, o_per_we, o_per_addr, o_per_wdata,
    input  i_per_ack, i_per_rdata, i_per_irq
  );

  modport slave (
    input  o_per_req, o_per_we, o_per_addr, o_per_wdata,
    output i_per_ack, i_per_rdata, i_per_irq
  );
endinterface

// File: rtl/iosc_skin_bridge_irq.sv
// Interrupt pending/mask registers with W1C clear, level set and a registered
// masked output. Sets always win over a clear in the same cycle.
module iosc_skin_bridge_irq
  import iosc_skin_bridge_pkg::*;
#(
  parameter int DW = IOSC_SKIN_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] irq_src,
  input  logic [DW-1:0] w1c_clear,
  input  logic          mask_we,
  input  logic [DW-1:0] mask_wdata,
  input  logic          err_set,
  output logic [DW-1:0] pending,
  output logic [DW-1:0] mask,
  output logic [DW-1:0] irq_out
);

  logic [DW-1:0] err_vec;

  always_comb begin
    err_vec = '0;
    err_vec[IOSC_SKIN_ERR_BIT] = err_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      mask    <= '0;
      irq_out <= '0;
    end else begin
      pending <= (pending & ~w1c_clear) | irq_src | err_vec;
      if (mask_we) begin
        mask <= mask_wdata;
      end
      irq_out <= pending & mask;
    end
  end

endmodule

// File: rtl/iosc_skin_bridge.sv
// Skin-side request to registered peripheral req/ack bridge with local
// PEND/MASK registers. Optional ack watchdog: define IOSC_SKIN_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for oen/ien; latches address, data and direction
// LOCAL | one-cycle access to the local PEND/MASK window
// PREQ  | o_per_req high, waiting for i_per_ack
// DONE  | publish read data, drop busy
// ERR   | watchdog expired: all-ones read data, error interrupt bit
module iosc_skin_bridge
  import iosc_skin_bridge_pkg::*;
#(
  parameter int                    DATA_WIDTH = IOSC_SKIN_DW,
  parameter logic [DATA_WIDTH-1:0] LOCAL_BASE = 'hFFF0,
  parameter int                    TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_skin_oen,
  input  logic                  i_skin_ien,
  input  logic [DATA_WIDTH-1:0] i_skin_addr,
  input  logic [DATA_WIDTH-1:0] i_skin_data,
  output logic [DATA_WIDTH-1:0] o_skin_data,
  output logic [DATA_WIDTH-1:0] o_skin_interrupt,
  output logic                  o_skin_busy,
  iosc_skin_bridge_if.master    per
);

  iosc_skin_state_e      state;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] local_rdata;
  logic [DATA_WIDTH-1:0] w1c_clear;
  logic [DATA_WIDTH-1:0] pending;
  logic [DATA_WIDTH-1:0] mask;
  logic [3:0]            offset;
  logic                  local_hit;
  logic                  local_wr;
  logic                  mask_we;
  logic                  err_set;

`ifdef IOSC_SKIN_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt;

  assign err_set = (state == IOSC_SKIN_ERR);
`else
  assign err_set = 1'b0;
`endif

  assign local_hit = (i_skin_addr[DATA_WIDTH-1:4] == LOCAL_BASE[DATA_WIDTH-1:4]);
  assign offset    = per.o_per_addr[3:0];
  assign local_wr  = (state == IOSC_SKIN_LOCAL) && per.o_per_we;
  assign mask_we   = local_wr && (offset == IOSC_SKIN_MASK_OFF);
  assign w1c_clear = (local_wr && (offset == IOSC_SKIN_PEND_OFF)) ? per.o_per_wdata : '0;

  always_comb begin
    local_rdata = '0;
    case (offset)
      IOSC_SKIN_PEND_OFF: local_rdata = pending;
      IOSC_SKIN_MASK_OFF: local_rdata = mask;
      default:            local_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IOSC_SKIN_IDLE;
      per.o_per_req   <= 1'b0;
      per.o_per_we    <= 1'b0;
      per.o_per_addr  <= '0;
      per.o_per_wdata <= '0;
      o_skin_busy     <= 1'b0;
      o_skin_data     <= '0;
      rdata_q         <= '0;
`ifdef IOSC_SKIN_TIMEOUT_EN
      cnt             <= '0;
`endif
    end else begin
      case (state)
        IOSC_SKIN_IDLE: begin
          if (i_skin_oen || i_skin_ien) begin
            // oen wins when both are raised: the access becomes a write
            per.o_per_we    <= i_skin_oen;
            per.o_per_addr  <= i_skin_addr;
            per.o_per_wdata <= i_skin_data;
            o_skin_busy     <= 1'b1;
            if (local_hit) begin
              state <= IOSC_SKIN_LOCAL;
            end else begin
              state         <= IOSC_SKIN_PREQ;
              per.o_per_req <= 1'b1;
            end
`ifdef IOSC_SKIN_TIMEOUT_EN
            cnt <= '0;
`endif
          end
        end
        IOSC_SKIN_LOCAL: begin
          rdata_q <= local_rdata;
          state   <= IOSC_SKIN_DONE;
        end
        IOSC_SKIN_PREQ: begin
          if (per.i_per_ack) begin
            per.o_per_req <= 1'b0;
            if (!per.o_per_we) begin
              rdata_q <= per.i_per_rdata;
            end
            state <= IOSC_SKIN_DONE;
          end
`ifdef IOSC_SKIN_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            per.o_per_req <= 1'b0;
            state         <= IOSC_SKIN_ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        IOSC_SKIN_DONE: begin
          if (!per.o_per_we) begin
            o_skin_data <= rdata_q;
          end
          o_skin_busy <= 1'b0;
          state       <= IOSC_SKIN_IDLE;
        end
`ifdef IOSC_SKIN_TIMEOUT_EN
        IOSC_SKIN_ERR: begin
          if (!per.o_per_we) begin
            o_skin_data <= IOSC_SKIN_ERR_RDATA;
          end
          o_skin_busy <= 1'b0;
          state       <= IOSC_SKIN_IDLE;
        end
`endif
        default: begin
          state <= IOSC_SKIN_IDLE;
        end
      endcase
    end
  end

  iosc_skin_bridge_irq #(
    .DW (DATA_WIDTH)
  ) u_irq (
    .clk        (clk),
    .rst        (rst),
    .irq_src    (per.i_per_irq),
    .w1c_clear  (w1c_clear),
    .mask_we    (mask_we),
    .mask_wdata (per.o_per_wdata),
    .err_set    (err_set),
    .pending    (pending),
    .mask       (mask),
    .irq_out    (o_skin_interrupt)
  );

endmodule

// File: tb/tb_iosc_skin_bridge.sv
// Directed bench for iosc_skin_bridge: peripheral reads/writes, local
// PEND/MASK registers, interrupt timing, watchdog and reset recovery.
module tb_iosc_skin_bridge;
  import iosc_skin_bridge_pkg::*;

  localparam int DW = IOSC_SKIN_DW;

  logic          clk;
  logic          rst;
  logic          i_skin_oen;
  logic          i_skin_ien;
  logic [DW-1:0] i_skin_addr;
  logic [DW-1:0] i_skin_data;
  logic [DW-1:0] o_skin_data;
  logic [DW-1:0] o_skin_interrupt;
  logic          o_skin_busy;

  int checks = 0;
  int errors = 0;

  iosc_skin_bridge_if per_if ();

  iosc_skin_bridge dut (
    .clk              (clk),
    .rst              (rst),
    .i_skin_oen       (i_skin_oen),
    .i_skin_ien       (i_skin_ien),
    .i_skin_addr      (i_skin_addr),
    .i_skin_data      (i_skin_data),
    .o_skin_data      (o_skin_data),
    .o_skin_interrupt (o_skin_interrupt),
    .o_skin_busy      (o_skin_busy),
    .per              (per_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Called at a falling edge; presents one request for a single rising edge
  // and pulses ack at the ack_at-th falling edge after acceptance (-1: never).
  task automatic do_access(input logic oen, input logic ien, input logic [DW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] rd,
                           input int ack_at, input int budget,
                           output int busy_cyc, output int req_cyc,
                           output logic we_any, output logic we_all);
    i_skin_oen  = oen;
    i_skin_ien  = ien;
    i_skin_addr = a;
    i_skin_data = d;
    @(negedge clk);
    i_skin_oen = 1'b0;
    i_skin_ien = 1'b0;
    busy_cyc = 0;
    req_cyc  = 0;
    we_any   = 1'b0;
    we_all   = 1'b1;
    for (int i = 0; i < budget && o_skin_busy; i++) begin
      busy_cyc++;
      if (per_if.o_per_req) begin
        req_cyc++;
        we_any = we_any | per_if.o_per_we;
        we_all = we_all & per_if.o_per_we;
      end
      per_if.i_per_ack   = (i == ack_at);
      per_if.i_per_rdata = rd;
      @(negedge clk);
    end
    per_if.i_per_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_skin_busy !== 1'b0 || per_if.o_per_req !== 1'b0 || per_if.o_per_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b req=%b we=%b, required 0 0 0",
               o_skin_busy, per_if.o_per_req, per_if.o_per_we);
    end
    checks++;
    if (o_skin_data !== '0 || o_skin_interrupt !== '0 || per_if.o_per_addr !== '0) begin
      errors++;
      $display("FAIL reset_data: data=%h irq=%h addr=%h, required all zero",
               o_skin_data, o_skin_interrupt, per_if.o_per_addr);
    end
  endtask

  task automatic test_per_read();
    int bc, rc;
    logic wa, wl;
    do_access(1'b0, 1'b1, 32'h0000_0100, 32'h0, 32'h1234_5678, 2, 50, bc, rc, wa, wl);
    checks++;
    if (bc != 4) begin
      errors++;
      $display("FAIL per_read_busy: busy cycles %0d, required 4", bc);
    end
    checks++;
    if (rc != 3 || wa !== 1'b0) begin
      errors++;
      $display("FAIL per_read_req: req cycles %0d we_seen %b, required 3 and 0", rc, wa);
    end
    checks++;
    if (per_if.o_per_addr !== 32'h0000_0100) begin
      errors++;
      $display("FAIL per_read_addr: got %h, required 00000100", per_if.o_per_addr);
    end
    checks++;
    if (o_skin_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL per_read_data: got %h, required 12345678", o_skin_data);
    end
  endtask

  task automatic test_write_both();
    int bc, rc;
    logic wa, wl;
    do_access(1'b1, 1'b1, 32'h0000_0200, 32'h0000_A5A5, 32'hDEAD_BEEF, 1, 50, bc, rc, wa, wl);
    checks++;
    if (rc != 2 || wl !== 1'b1) begin
      errors++;
      $display("FAIL write_we: req cycles %0d we_all %b, required 2 and 1", rc, wl);
    end
    checks++;
    if (per_if.o_per_wdata !== 32'h0000_A5A5 || per_if.o_per_addr !== 32'h0000_0200) begin
      errors++;
      $display("FAIL write_latch: wdata=%h addr=%h, required 0000a5a5 00000200",
               per_if.o_per_wdata, per_if.o_per_addr);
    end
    checks++;
    if (o_skin_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_keeps_data: got %h, required 12345678", o_skin_data);
    end
  endtask

  task automatic test_mask_irq();
    int bc, rc;
    logic wa, wl;
    do_access(1'b1, 1'b0, 32'h0000_FFF4, 32'h0000_0003, 32'h0, -1, 50, bc, rc, wa, wl);
    checks++;
    if (bc != 2 || rc != 0) begin
      errors++;
      $display("FAIL local_timing: busy %0d req %0d, required 2 and 0", bc, rc);
    end
    per_if.i_per_irq = 32'h5;
    @(negedge clk);
    per_if.i_per_irq = 32'h0;
    checks++;
    if (o_skin_interrupt !== 32'h0) begin
      errors++;
      $display("FAIL irq_one_edge: got %h, required 00000000", o_skin_interrupt);
    end
    @(negedge clk);
    checks++;
    if (o_skin_interrupt !== 32'h1) begin
      errors++;
      $display("FAIL irq_two_edges: got %h, required 00000001", o_skin_interrupt);
    end
    do_access(1'b0, 1'b1, 32'h0000_FFF0, 32'h0, 32'h0, -1, 50, bc, rc, wa, wl);
    checks++;
    if (o_skin_data !== 32'h5) begin
      errors++;
      $display("FAIL pend_read: got %h, required 00000005", o_skin_data);
    end
    do_access(0, 1, 32'h0000_FFF4, 32'h0, 32'h0, -1, 50, bc, rc, wa, wl);
    checks++;
    if (o_skin_data !== 32'h3) begin
      errors++;
      $display("FAIL mask_read: got %h, required 00000003", o_skin_data);
    end
    do_access(1'b1, 1'b0, 32'h0000_FFF8, 32'hFFFF_FFFF, 32'h0, -1, 50, bc, rc, wa, wl);
    do_access(1'b0, 1'b1, 32'h0000_FFF8, 32'h0, 32'h0, -1, 50, bc, rc, wa, wl);
    checks++;
    if (o_skin_data !== 32'h0) begin
      errors++;
      $display("FAIL other_off: got %h, required 00000000", o_skin_data);
    end
  endtask

  task automatic test_w1c();
    int bc, rc;
    logic wa, wl;
    per_if.i_per_irq = 32'h1;
    do_access(1'b1, 1'b0, 32'h0000_FFF0, 32'h1, 32'h0, -1, 50, bc, rc, wa, wl);
    per_if.i_per_irq = 32'h0;
    do_access(1'b0, 1'b1, 32'h0000_FFF0, 32'h0, 32'h0, -1, 50, bc, rc, wa, wl);
    checks++;
    if (o_skin_data !== 32'h5) begin
      errors++;
      $display("FAIL w1c_set_wins: got %h, required 00000005", o_skin_data);
    end
    do_access(1'b1, 1'b0, 32'h0000_FFF0, 32'h1, 32'h0, -1, 50, bc, rc, wa, wl);
    do_access(1'b0, 1'b1, 32'h0000_FFF0, 32'h0, 32'h0, -1, 50, bc, rc, wa, wl);
    checks++;
    if (o_skin_data !== 32'h4) begin
      errors++;
      $display("FAIL w1c_clear: got %h, required 00000004", o_skin_data);
    end
    checks++;
    if (o_skin_interrupt !== 32'h0) begin
      errors++;
      $display("FAIL w1c_irq_out: got %h, required 00000000", o_skin_interrupt);
    end
  endtask

  task automatic test_back_to_back();
    int bc, rc;
    logic wa, wl;
    do_access(1'b1, 1'b0, 32'h0000_0500, 32'h0000_1111, 32'h0, 0, 50, bc, rc, wa, wl);
    checks++;
    if (bc != 2 || rc != 1) begin
      errors++;
      $display("FAIL b2b_write: busy %0d req %0d, required 2 and 1", bc, rc);
    end
    do_access(1'b0, 1'b1, 32'h0000_0600, 32'h0, 32'hCAFE_0001, 0, 50, bc, rc, wa, wl);
    checks++;
    if (bc != 2 || o_skin_data !== 32'hCAFE_0001 || per_if.o_per_addr !== 32'h0000_0600) begin
      errors++;
      $display("FAIL b2b_read: busy %0d data %h addr %h, required 2 cafe0001 00000600",
               bc, o_skin_data, per_if.o_per_addr);
    end
  endtask

  task automatic test_timeout();
    int bc, rc;
    logic wa, wl;
    do_access(1'b0, 1'b1, 32'h0000_0700, 32'h0, 32'h0, -1, 40, bc, rc, wa, wl);
`ifdef IOSC_SKIN_TIMEOUT_EN
    checks++;
    if (bc != 16 || rc != 15) begin
      errors++;
      $display("FAIL timeout_len: busy %0d req %0d, required 16 and 15", bc, rc);
    end
    checks++;
    if (o_skin_data !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL timeout_data: got %h, required ffffffff", o_skin_data);
    end
    do_access(1'b0, 1'b1, 32'h0000_FFF0, 32'h0, 32'h0, -1, 50, bc, rc, wa, wl);
    checks++;
    if (o_skin_data !== 32'h8000_0004) begin
      errors++;
      $display("FAIL timeout_pend: got %h, required 80000004", o_skin_data);
    end
`else
    checks++;
    if (bc != 40 || o_skin_busy !== 1'b1 || per_if.o_per_req !== 1'b1) begin
      errors++;
      $display("FAIL no_watchdog_hold: busy cycles %0d busy %b req %b, required 40 1 1",
               bc, o_skin_busy, per_if.o_per_req);
    end
`endif
  endtask

  task automatic test_reset_mid_preq();
    int bc, rc;
    logic wa, wl;
    i_skin_ien  = 1'b1;
    i_skin_addr = 32'h0000_0300;
    @(negedge clk);
    i_skin_ien = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (per_if.o_per_req !== 1'b1) begin
      errors++;
      $display("FAIL preq_before_reset: req %b, required 1", per_if.o_per_req);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    per_if.i_per_ack   = 1'b1;
    per_if.i_per_rdata = 32'h5555_5555;
    @(negedge clk);
    per_if.i_per_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (o_skin_busy !== 1'b0 || per_if.o_per_req !== 1'b0 || per_if.o_per_we !== 1'b0 ||
        per_if.o_per_addr !== '0 || per_if.o_per_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mid_preq_ctrl: busy=%b req=%b we=%b addr=%h wdata=%h, required zeros",
               o_skin_busy, per_if.o_per_req, per_if.o_per_we,
               per_if.o_per_addr, per_if.o_per_wdata);
    end
    checks++;
    if (o_skin_data !== '0 || o_skin_interrupt !== '0) begin
      errors++;
      $display("FAIL reset_mid_preq_data: data=%h irq=%h, required zeros",
               o_skin_data, o_skin_interrupt);
    end
    do_access(1'b0, 1'b1, 32'h0000_FFF4, 32'h0, 32'h0, -1, 50, bc, rc, wa, wl);
    checks++;
    if (bc != 2 || o_skin_data !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_idle: busy %0d data %h, required 2 00000000", bc, o_skin_data);
    end
  endtask

  initial begin
    rst                = 1'b1;
    i_skin_oen         = 1'b0;
    i_skin_ien         = 1'b0;
    i_skin_addr        = '0;
    i_skin_data        = '0;
    per_if.i_per_ack   = 1'b0;
    per_if.i_per_rdata = '0;
    per_if.i_per_irq   = '0;
    test_reset();
    test_per_read();
    test_write_both();
    test_mask_irq();
    test_w1c();
    test_back_to_back();
    test_timeout();
    test_reset_mid_preq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "time limit");
  end

endmodule
